dmux8way_sched: RTL and testbench
=================================

// Module: dmux8way_sched
// PURPOSE
//  Round-robin scheduler feeding the 8-way demultiplexer datapath. Accepts
//  W-bit words over a valid/ready handshake and registers each word. Drives
//  the 3-bit lane select and steers each word to the next enabled output lane.
//  Holds the word until that lane accepts it or a timeout expires.
//  Sits between a single producer and eight lane consumers.
// PARAMETERS
//  W        4    data width of in_data/out_data
//  TIMEOUT  15   max cycles a word waits on a lane before drop; 0 = never drop
// PORTS
//  clk        in   1  rising-edge clock
//  rst_n      in   1  asynchronous active-low reset
//  in_data    in   W  input word
//  in_valid   in   1  producer has a word
//  in_ready   out  1  scheduler accepts this cycle
//  lane_mask  in   8  bit i=1: lane i eligible for new words
//  out_ready  in   8  bit i=1: lane i consumer accepts this cycle
//  out_data   out  W  held word (common to all lanes)
//  sel        out  3  lane currently addressed
//  out_valid  out  8  one-hot valid, bit sel set while HOLD, else 0
//  drop       out  1  1-cycle pulse: held word discarded on timeout
//  idle       out  1  1 when state==IDLE
//  stat_sel   in   3  lane whose delivery count is read
//  stat_cnt   out  8  delivery count of lane stat_sel
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, ptr=0, sel=0, out_data=0,
//    out_valid=0, drop=0, wait counter=0, all stat counters=0. A word held at
//    reset is lost.
//  - States: IDLE (no word held), HOLD (word held for lane sel).
//  - Lane pick: first i with lane_mask[i]=1, searching ptr, ptr+1, ..., 7, 0,
//    ..., ptr-1 (mod 8). lane_mask==0 gives no pick.
//  - in_ready = pick exists AND (IDLE OR (HOLD AND out_ready[sel])).
//    Combinational; it never depends on in_valid.
//  - Accept = in_valid & in_ready. On accept, at the next edge:
//    out_data<=in_data, sel<=pick, ptr<=pick+1 (3-bit wrap, 7->0), state<=HOLD,
//    wait counter<=0.
//  - Latency: a word accepted at edge N is presented at cycle N+1.
//  - Delivery: in HOLD with out_ready[sel]=1, the word is consumed at that edge.
//    - With a simultaneous accept, the new word is loaded the same edge, giving
//      back-to-back 1 word/cycle.
//    - Without one, state<=IDLE.
//  - Timeout (TIMEOUT>0): in HOLD without delivery, the wait counter
//    increments. The word is discarded at the edge where the counter would reach
//    TIMEOUT, i.e. the word is offered for exactly TIMEOUT cycles. That edge:
//    drop pulses for 1 cycle, state<=IDLE, ptr unchanged. No accept occurs that
//    cycle, since in_ready requires out_ready[sel].
//  - The counter is ceil(log2(TIMEOUT+1)) bits and saturates; it never wraps.
//  - lane_mask changes affect only future picks. A held word stays on its lane
//    even if that lane is masked off.
//  - out_ready bits other than sel are ignored.
//  - out_valid is a register-derived one-hot and is zero in IDLE.
// CONFIGURATION
//  DMUX8WAY_SCHED_STATS_EN defined:
//  - Eight 8-bit delivery counters, one per lane.
//  - Lane sel's counter increments on each delivery and wraps 255->0.
//  - Drops are not counted.
//  - stat_cnt = counter[stat_sel], combinational.
//  Undefined: no counters are built and stat_cnt is constant 0. Ports and all
//  other behaviour are identical.
// TESTING
//  - Reset mid-HOLD (rst_n low async): outputs reach reset values immediately,
//    idle=1, ptr=0.
//  - lane_mask=8'hFF, out_ready=8'hFF, in_valid held high, data 1,2,...,9:
//    one word per cycle; sel=0,1,...,7,0; out_data matches with 1-cycle latency.
//  - lane_mask=8'b1010_0100, ptr=0: three accepts go to lanes 2,5,7, then lane
//    2 again (wrap).
//  - lane_mask=0 with in_valid=1: in_ready stays 0, idle=1, no activity.
//  - TIMEOUT=15, out_ready=0 after an accept of 4'hA on lane 3:
//    - out_valid=8'h08 is held for 15 cycles.
//    - drop pulses once and idle=1.
//    - The next pick is lane 4.
//  - STATS_EN, out_ready=8'hFF: 300 deliveries to lane 1 only
//    (lane_mask=8'h02) -> stat_sel=1 reads 44 (300 mod 256); other lanes read 0.
//    With the macro undefined, stat_cnt reads 0.

Source files
------------

// File: rtl/dmux8way_sched.sv
// dmux8way_sched: round-robin scheduler in front of an 8-way demultiplexer.
// Registers one W-bit word at a time and steers it to the next enabled lane.
// Holds the word until that lane takes it or the wait timeout expires.
// Optional per-lane delivery counters are built when DMUX8WAY_SCHED_STATS_EN
// is defined. Otherwise stat_cnt is tied to zero.
module dmux8way_sched #(
    parameter int W       = 4,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   lane_mask,
    input  logic [7:0]   out_ready,
    output logic [W-1:0] out_data,
    output logic [2:0]   sel,
    output logic [7:0]   out_valid,
    output logic         drop,
    output logic         idle,
    input  logic [2:0]   stat_sel,
    output logic [7:0]   stat_cnt
);

    // The wait counter only ever needs to count up to TIMEOUT-1.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] WMAX = '1;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t         r_state;
    state_t         w_nextState;
    logic [2:0]     r_ptr;
    logic [2:0]     r_sel;
    logic [W-1:0]   r_data;
    logic [CW-1:0]  r_wait;
    logic           r_drop;

    logic           w_hold;
    logic           w_pickValid;
    logic [2:0]     w_pick;
    logic           w_deliver;
    logic           w_inReady;
    logic           w_accept;
    logic           w_timeoutHit;

    assign w_hold       = (r_state == HOLD);
    assign w_deliver    = w_hold && out_ready[r_sel];
    assign w_inReady    = w_pickValid && (!w_hold || out_ready[r_sel]);
    assign w_accept     = in_valid && w_inReady;
    assign w_timeoutHit = (TIMEOUT > 0) && w_hold && !w_deliver && (r_wait == LAST);

    // Round-robin search starting at ptr; the loop runs from the farthest offset
    // down so the nearest enabled lane is the one left standing.
    always_comb begin
        logic [2:0] idx;
        w_pickValid = 1'b0;
        w_pick      = '0;
        for (int k = 7; k >= 0; k--) begin
            idx = r_ptr + 3'(k);
            if (lane_mask[idx]) begin
                w_pickValid = 1'b1;
                w_pick      = idx;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: a new accept always wins, then delivery, then timeout.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = HOLD;
                end
            end
            HOLD: begin
                if (w_accept) begin
                    w_nextState = HOLD;
                end else if (w_deliver || w_timeoutHit) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Held word, lane select, search pointer, wait counter and drop pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_sel  <= '0;
            r_ptr  <= '0;
            r_wait <= '0;
            r_drop <= 1'b0;
        end else begin
            r_drop <= w_timeoutHit;
            if (w_accept) begin
                r_data <= in_data;
                r_sel  <= w_pick;
                r_ptr  <= w_pick + 3'd1;
                r_wait <= '0;
            end else if ((TIMEOUT > 0) && w_hold && !w_deliver && !w_timeoutHit &&
                         (r_wait != WMAX)) begin
                r_wait <= r_wait + 1'b1;
            end
        end
    end

    assign in_ready  = w_inReady;
    assign out_data  = r_data;
    assign sel       = r_sel;
    assign out_valid = w_hold ? (8'b0000_0001 << r_sel) : 8'h00;
    assign drop      = r_drop;
    assign idle      = !w_hold;

`ifdef DMUX8WAY_SCHED_STATS_EN
    logic [7:0] r_stat [8];

    // Per-lane delivery counters; drops are not counted, counters wrap at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                r_stat[i] <= '0;
            end
        end else if (w_deliver) begin
            r_stat[r_sel] <= r_stat[r_sel] + 8'd1;
        end
    end

    assign stat_cnt = r_stat[stat_sel];
`else
    logic w_unusedStatSel;
    assign w_unusedStatSel = ^stat_sel;
    assign stat_cnt        = 8'h00;
`endif

endmodule

// File: tb/tb_dmux8way_sched.sv
// Testbench for dmux8way_sched (W=4, TIMEOUT=15).
// Uses fixed vectors, hand sequences and a randomized run against a behavioural model.
module tb_dmux8way_sched;

    localparam int W       = 4;
    localparam int TIMEOUT = 15;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   lane_mask = '0;
    logic [7:0]   out_ready = '0;
    logic [W-1:0] out_data;
    logic [2:0]   sel;
    logic [7:0]   out_valid;
    logic         drop;
    logic         idle;
    logic [2:0]   stat_sel = '0;
    logic [7:0]   stat_cnt;

    int errors = 0;
    int checks = 0;

    dmux8way_sched #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .lane_mask(lane_mask), .out_ready(out_ready),
        .out_data(out_data), .sel(sel), .out_valid(out_valid), .drop(drop),
        .idle(idle), .stat_sel(stat_sel), .stat_cnt(stat_cnt)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // ---------------- behavioural reference model ----------------
    bit         mHeld;
    int         mSel, mPtr, mWait, mData;
    bit         mDrop;
    int         mCnt [8];

    function automatic int pickLane(input int ptr, input logic [7:0] mask);
        for (int k = 0; k < 8; k++) begin
            if (mask[(ptr + k) % 8]) return (ptr + k) % 8;
        end
        return -1;
    endfunction

    task automatic modelReset();
        mHeld = 0; mSel = 0; mPtr = 0; mWait = 0; mData = 0; mDrop = 0;
        for (int i = 0; i < 8; i++) mCnt[i] = 0;
    endtask

    function automatic bit modelReady(input logic [7:0] mask, input logic [7:0] ordy);
        return (pickLane(mPtr, mask) >= 0) && (!mHeld || ordy[mSel]);
    endfunction

    task automatic modelStep(input bit v, input int d, input logic [7:0] mask,
                             input logic [7:0] ordy);
        int  p;
        bit  acc, dlv;
        p   = pickLane(mPtr, mask);
        acc = v && modelReady(mask, ordy);
        dlv = mHeld && ordy[mSel];
        mDrop = 0;
        if (dlv) mCnt[mSel] = (mCnt[mSel] + 1) % 256;
        if (acc) begin
            mHeld = 1; mSel = p; mData = d; mPtr = (p + 1) % 8; mWait = 0;
        end else if (dlv) begin
            mHeld = 0;
        end else if (mHeld && TIMEOUT > 0) begin
            if (mWait + 1 == TIMEOUT) begin
                mHeld = 0; mDrop = 1;
            end else begin
                mWait = mWait + 1;
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [W-1:0] d, input logic [7:0] mask,
                                 input logic [7:0] ordy);
        in_valid  = v;
        in_data   = d;
        lane_mask = mask;
        out_ready = ordy;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, '0, 8'h00, 8'h00);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        modelReset();
    endtask

    function automatic logic [7:0] expStat(input int lane1Count);
`ifdef DMUX8WAY_SCHED_STATS_EN
        return 8'(lane1Count % 256);
`else
        return 8'(lane1Count * 0);
`endif
    endfunction

    typedef struct {
        bit         v;
        logic [3:0] d;
        logic [7:0] mask;
        logic [7:0] ordy;
        bit         expReady;
        logic [2:0] expSel;
        logic [3:0] expData;
        logic [7:0] expOv;
        bit         expIdle;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int validCycles, dropCount, lane1;

        // Lane mask 1010_0100 from ptr 0: lanes 2,5,7 then 2 again, then drain.
        vecs[0] = '{1'b1, 4'h1, 8'hA4, 8'hFF, 1'b1, 3'd2, 4'h1, 8'h04, 1'b0};
        vecs[1] = '{1'b1, 4'h2, 8'hA4, 8'hFF, 1'b1, 3'd5, 4'h2, 8'h20, 1'b0};
        vecs[2] = '{1'b1, 4'h3, 8'hA4, 8'hFF, 1'b1, 3'd7, 4'h3, 8'h80, 1'b0};
        vecs[3] = '{1'b1, 4'h4, 8'hA4, 8'hFF, 1'b1, 3'd2, 4'h4, 8'h04, 1'b0};
        vecs[4] = '{1'b0, 4'h0, 8'hA4, 8'hFF, 1'b1, 3'd2, 4'h4, 8'h00, 1'b1};

        doReset();

        // Reset values.
        checkOutput("rst_idle", 32'(idle), 32'd1);
        checkOutput("rst_sel", 32'(sel), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_drop", 32'(drop), 32'd0);
        checkOutput("rst_stat", 32'(stat_cnt), 32'd0);

        // Table-driven vectors.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].v, vecs[i].d, vecs[i].mask, vecs[i].ordy);
            #4;
            checkOutput($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].expReady));
            @(posedge clk); #1;
            checkOutput($sformatf("vec%0d_sel", i), 32'(sel), 32'(vecs[i].expSel));
            checkOutput($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].expData));
            checkOutput($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].expOv));
            checkOutput($sformatf("vec%0d_idle", i), 32'(idle), 32'(vecs[i].expIdle));
        end

        // Full-rate streaming on all lanes: sel 0..7,0 with 1-cycle latency.
        doReset();
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(1'b1, 4'(i), 8'hFF, 8'hFF);
            #4 checkOutput($sformatf("stream%0d_ready", i), 32'(in_ready), 32'd1);
            @(posedge clk); #1;
            checkOutput($sformatf("stream%0d_sel", i), 32'(sel), 32'((i - 1) % 8));
            checkOutput($sformatf("stream%0d_data", i), 32'(out_data), 32'(i));
        end

        // Asynchronous reset in the middle of HOLD.
        applyStimulus(1'b0, '0, 8'hFF, 8'h00);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("midrst_idle", 32'(idle), 32'd1);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_sel", 32'(sel), 32'd0);
        checkOutput("midrst_data", 32'(out_data), 32'd0);
        checkOutput("midrst_drop", 32'(drop), 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(1'b1, 4'h5, 8'hFF, 8'h00);
        @(posedge clk); #1;
        checkOutput("midrst_ptr_pick", 32'(sel), 32'd0);

        // Empty mask: nothing is ever accepted.
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 4'(i + 3), 8'h00, 8'hFF);
            #4;
            checkOutput("nomask_ready", 32'(in_ready), 32'd0);
            checkOutput("nomask_idle", 32'(idle), 32'd1);
            @(posedge clk); #1;
        end

        // Timeout: 4'hA on lane 3, never accepted, offered exactly 15 cycles.
        doReset();
        applyStimulus(1'b1, 4'hA, 8'h08, 8'h00);
        @(posedge clk); #1;
        applyStimulus(1'b0, 4'h0, 8'h08, 8'h00);
        checkOutput("to_sel", 32'(sel), 32'd3);
        checkOutput("to_data", 32'(out_data), 32'hA);
        validCycles = 0;
        dropCount   = 0;
        for (int c = 0; c < 40; c++) begin
            #4;
            if (out_valid == 8'h08) validCycles++;
            if (drop) dropCount++;
            @(posedge clk); #1;
        end
        checkOutput("to_valid_cycles", 32'(validCycles), 32'd15);
        checkOutput("to_drop_pulses", 32'(dropCount), 32'd1);
        checkOutput("to_idle", 32'(idle), 32'd1);
        applyStimulus(1'b1, 4'h6, 8'hFF, 8'h00);
        @(posedge clk); #1;
        applyStimulus(1'b0, 4'h0, 8'hFF, 8'h00);
        checkOutput("to_next_pick", 32'(sel), 32'd4);

        // Delivery statistics: 300 words to lane 1.
        doReset();
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 4'(i), 8'h02, 8'hFF);
            @(posedge clk); #1;
        end
        applyStimulus(1'b0, 4'h0, 8'h02, 8'hFF);
        @(posedge clk); #1;
        lane1 = 300;
        for (int s = 0; s < 8; s++) begin
            stat_sel = 3'(s);
            #1;
            checkOutput($sformatf("stat_lane%0d", s), 32'(stat_cnt),
                        (s == 1) ? 32'(expStat(lane1)) : 32'd0);
        end
        stat_sel = 3'd0;

        // Randomized run against the behavioural model.
        doReset();
        for (int c = 0; c < 600; c++) begin
            bit         v;
            logic [3:0] d;
            logic [7:0] mask, ordy;
            v    = 1'($urandom_range(0, 1));
            d    = 4'($urandom);
            mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            ordy = ((c % 60) < 25) ? 8'h00 : 8'($urandom);
            stat_sel = 3'($urandom);
            applyStimulus(v, d, mask, ordy);
            #4;
            checkOutput("rnd_in_ready", 32'(in_ready), 32'(modelReady(mask, ordy)));
            checkOutput("rnd_idle", 32'(idle), 32'(!mHeld));
            checkOutput("rnd_out_valid", 32'(out_valid), mHeld ? (32'd1 << mSel) : 32'd0);
            checkOutput("rnd_sel", 32'(sel), 32'(mSel));
            checkOutput("rnd_data", 32'(out_data), 32'(mData));
            checkOutput("rnd_drop", 32'(drop), 32'(mDrop));
`ifdef DMUX8WAY_SCHED_STATS_EN
            checkOutput("rnd_stat", 32'(stat_cnt), 32'(mCnt[stat_sel]));
`else
            checkOutput("rnd_stat", 32'(stat_cnt), 32'd0);
`endif
            modelStep(v, int'(d), mask, ordy);
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
